ace_ccu_rd_serializer: RTL and testbench

//  Sits between the shareable outputs of the per-port ACE demuxes and the extra CCU slave port of the

---
 rtl/ace_ccu_rd_serializer.sv | 167 ++++++++++++++++
 tb/tb_ace_ccu_rd_serializer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_ccu_rd_serializer.sv
// Round-robin arbiter and serializer for shareable ACE reads: one read in flight at a time.
// The winning port index is prefixed onto the AR ID, and R beats are steered back to that port.
module ace_ccu_rd_serializer #(
  parameter int unsigned NoSlvPorts = 2,
  parameter int unsigned IdWidth    = 4,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 64,
  localparam int unsigned IdxW      = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NoSlvPorts-1:0]           slv_ar_valid_i,
  output logic [NoSlvPorts-1:0]           slv_ar_ready_o,
  input  logic [NoSlvPorts*IdWidth-1:0]   slv_ar_id_i,
  input  logic [NoSlvPorts*AddrWidth-1:0] slv_ar_addr_i,
  input  logic [NoSlvPorts*8-1:0]         slv_ar_len_i,
  output logic [NoSlvPorts-1:0]           slv_r_valid_o,
  input  logic [NoSlvPorts-1:0]           slv_r_ready_i,
  output logic [IdWidth-1:0]              slv_r_id_o,
  output logic [DataWidth-1:0]            slv_r_data_o,
  output logic [1:0]                      slv_r_resp_o,
  output logic                            slv_r_last_o,
  output logic                            mst_ar_valid_o,
  input  logic                            mst_ar_ready_i,
  output logic [IdWidth+IdxW-1:0]         mst_ar_id_o,
  output logic [AddrWidth-1:0]            mst_ar_addr_o,
  output logic [7:0]                      mst_ar_len_o,
  input  logic                            mst_r_valid_i,
  output logic                            mst_r_ready_o,
  input  logic [IdWidth+IdxW-1:0]         mst_r_id_i,
  input  logic [DataWidth-1:0]            mst_r_data_i,
  input  logic [1:0]                      mst_r_resp_i,
  input  logic                            mst_r_last_i,
  output logic                            busy_o,
  output logic                            len_err_o
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                 state_reg, state_next;
  logic [IdxW-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [IdxW-1:0]        grant_reg, grant_next;
  logic [IdWidth-1:0]     id_reg, id_next;
  logic [AddrWidth-1:0]   addr_reg, addr_next;
  logic [7:0]             len_reg, len_next;
  logic [7:0]             beat_cnt_reg, beat_cnt_next;
  logic                   len_err_reg, len_err_next;

  logic [IdWidth-1:0]     ar_id   [NoSlvPorts];
  logic [AddrWidth-1:0]   ar_addr [NoSlvPorts];
  logic [7:0]             ar_len  [NoSlvPorts];
  logic [IdxW-1:0]        cand_idx [NoSlvPorts];
  logic [NoSlvPorts-1:0]  cand_req;
  logic                   grant_found;
  logic [IdxW-1:0]        grant_idx;
  logic                   r_hs;

  // cand_idx[k] is the port k positions after rr_ptr, wrapping at NoSlvPorts.
  for (genvar gi = 0; gi < NoSlvPorts; gi++) begin : g_port
    logic [IdxW:0] sum;
    assign ar_id[gi]   = slv_ar_id_i[gi*IdWidth +: IdWidth];
    assign ar_addr[gi] = slv_ar_addr_i[gi*AddrWidth +: AddrWidth];
    assign ar_len[gi]  = slv_ar_len_i[gi*8 +: 8];
    assign sum         = {1'b0, rr_ptr_reg} + (IdxW+1)'(gi);
    assign cand_idx[gi] = (sum >= (IdxW+1)'(NoSlvPorts))
                        ? IdxW'(sum - (IdxW+1)'(NoSlvPorts)) : sum[IdxW-1:0];
    assign cand_req[gi] = slv_ar_valid_i[cand_idx[gi]];
  end

  // Descending scan so the smallest offset from rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = int'(NoSlvPorts) - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[i];
      end
    end
  end

  assign r_hs = mst_r_valid_i && slv_r_ready_i[grant_reg];

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_next     = grant_reg;
    id_next        = id_reg;
    addr_next      = addr_reg;
    len_next       = len_reg;
    beat_cnt_next  = beat_cnt_reg;
    len_err_next   = 1'b0;
    slv_ar_ready_o = '0;
    slv_r_valid_o  = '0;
    mst_ar_valid_o = 1'b0;
    mst_r_ready_o  = 1'b0;
    case (state_reg)
      IDLE: begin
        // Ready is withheld during reset so no request is accepted and then lost.
        if (grant_found && !rst_i) begin
          slv_ar_ready_o[grant_idx] = 1'b1;
          grant_next    = grant_idx;
          id_next       = ar_id[grant_idx];
          addr_next     = ar_addr[grant_idx];
          len_next      = ar_len[grant_idx];
          beat_cnt_next = '0;
          rr_ptr_next   = (grant_idx == IdxW'(NoSlvPorts - 1)) ? '0 : grant_idx + IdxW'(1);
          state_next    = ADDR;
        end
      end
      ADDR: begin
        mst_ar_valid_o = 1'b1;
        if (mst_ar_ready_i) state_next = DATA;
      end
      DATA: begin
        slv_r_valid_o[grant_reg] = mst_r_valid_i;
        mst_r_ready_o            = slv_r_ready_i[grant_reg];
        if (r_hs) begin
          beat_cnt_next = beat_cnt_reg + 8'd1;
          len_err_next  = (mst_r_last_i && (beat_cnt_reg != len_reg)) ||
                          (!mst_r_last_i && (beat_cnt_reg == len_reg));
          if (mst_r_last_i) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      grant_reg    <= '0;
      id_reg       <= '0;
      addr_reg     <= '0;
      len_reg      <= '0;
      beat_cnt_reg <= '0;
      len_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      grant_reg    <= grant_next;
      id_reg       <= id_next;
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      beat_cnt_reg <= beat_cnt_next;
      len_err_reg  <= len_err_next;
    end
  end

  assign mst_ar_id_o   = {grant_reg, id_reg};
  assign mst_ar_addr_o = addr_reg;
  assign mst_ar_len_o  = len_reg;

  assign slv_r_id_o    = mst_r_id_i[IdWidth-1:0];
  assign slv_r_data_o  = mst_r_data_i;
  assign slv_r_resp_o  = mst_r_resp_i;
  assign slv_r_last_o  = mst_r_last_i;

  assign busy_o        = (state_reg != IDLE);
  assign len_err_o     = len_err_reg;

  // The port-index prefix on R is implied by grant_reg and not needed again.
  logic unused_r_idx;
  assign unused_r_idx = ^mst_r_id_i[IdWidth+IdxW-1:IdWidth];

endmodule

// File: tb/tb_ace_ccu_rd_serializer.sv
// Randomized scoreboard bench for ace_ccu_rd_serializer, followed by a mid-burst reset scenario.
module tb_ace_ccu_rd_serializer;
  localparam int NP   = 3;
  localparam int IW   = 4;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int IXW  = 2;
  localparam int MIW  = IW + IXW;
  localparam int REQS = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i;
  logic [NP-1:0]     slv_ar_valid_i, slv_ar_ready_o;
  logic [NP*IW-1:0]  slv_ar_id_i;
  logic [NP*AW-1:0]  slv_ar_addr_i;
  logic [NP*8-1:0]   slv_ar_len_i;
  logic [NP-1:0]     slv_r_valid_o, slv_r_ready_i;
  logic [IW-1:0]     slv_r_id_o;
  logic [DW-1:0]     slv_r_data_o;
  logic [1:0]        slv_r_resp_o;
  logic              slv_r_last_o;
  logic              mst_ar_valid_o, mst_ar_ready_i;
  logic [MIW-1:0]    mst_ar_id_o;
  logic [AW-1:0]     mst_ar_addr_o;
  logic [7:0]        mst_ar_len_o;
  logic              mst_r_valid_i, mst_r_ready_o;
  logic [MIW-1:0]    mst_r_id_i;
  logic [DW-1:0]     mst_r_data_i;
  logic [1:0]        mst_r_resp_i;
  logic              mst_r_last_i;
  logic              busy_o, len_err_o;

  ace_ccu_rd_serializer #(
    .NoSlvPorts(NP), .IdWidth(IW), .AddrWidth(AW), .DataWidth(DW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o),
    .slv_ar_id_i(slv_ar_id_i), .slv_ar_addr_i(slv_ar_addr_i), .slv_ar_len_i(slv_ar_len_i),
    .slv_r_valid_o(slv_r_valid_o), .slv_r_ready_i(slv_r_ready_i),
    .slv_r_id_o(slv_r_id_o), .slv_r_data_o(slv_r_data_o),
    .slv_r_resp_o(slv_r_resp_o), .slv_r_last_o(slv_r_last_o),
    .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
    .mst_ar_id_o(mst_ar_id_o), .mst_ar_addr_o(mst_ar_addr_o), .mst_ar_len_o(mst_ar_len_o),
    .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o),
    .mst_r_id_i(mst_r_id_i), .mst_r_data_i(mst_r_data_i),
    .mst_r_resp_i(mst_r_resp_i), .mst_r_last_i(mst_r_last_i),
    .busy_o(busy_o), .len_err_o(len_err_o)
  );

  typedef struct {
    int             port;
    logic [IW-1:0]  id;
    logic [AW-1:0]  addr;
    logic [7:0]     len;
  } ar_t;

  typedef struct {
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
    logic           err;
  } beat_t;

  ar_t   exp_ar_q[$];
  ar_t   txn_q[$];
  beat_t exp_r_q[$];
  beat_t src_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction phase (0 idle, 1 address, 2 data), round-robin pointer, owner.
  int             m_phase = 0;
  int             m_rr    = 0;
  int             m_port  = 0;
  logic [IW-1:0]  m_id;
  logic           err_due = 1'b0;
  int             g, pp;
  logic [NP-1:0]  exp_rdy, exp_v;
  ar_t            t_m;
  beat_t          b_m;

  always @(negedge clk) begin
    if (rst_i) begin
      m_phase = 0; m_rr = 0; err_due = 1'b0;
      exp_ar_q.delete(); txn_q.delete(); exp_r_q.delete();
    end else begin
      check("len_err", len_err_o, err_due);
      err_due = 1'b0;
      check("busy", busy_o, m_phase != 0);
      check("mst_ar_valid", mst_ar_valid_o, m_phase == 1);
      if (m_phase != 2) begin
        check("r_valid_outside_data", slv_r_valid_o, 0);
        check("r_ready_outside_data", mst_r_ready_o, 0);
      end
      if (m_phase == 0) begin
        g = -1;
        for (int k = 0; k < NP; k++) begin
          pp = (m_rr + k) % NP;
          if (g < 0 && slv_ar_valid_i[pp]) g = pp;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("ar_ready_grant", slv_ar_ready_o, exp_rdy);
        if (g >= 0) begin
          t_m.port = g;
          t_m.id   = slv_ar_id_i[g*IW +: IW];
          t_m.addr = slv_ar_addr_i[g*AW +: AW];
          t_m.len  = slv_ar_len_i[g*8 +: 8];
          exp_ar_q.push_back(t_m);
          txn_q.push_back(t_m);
          m_port  = g;
          m_id    = t_m.id;
          m_rr    = (g + 1) % NP;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        check("ar_ready_busy", slv_ar_ready_o, 0);
        if (exp_ar_q.size() > 0) begin
          t_m = exp_ar_q[0];
          check("mst_ar_id", mst_ar_id_o, {t_m.port[IXW-1:0], t_m.id});
          check("mst_ar_addr", mst_ar_addr_o, t_m.addr);
          check("mst_ar_len", mst_ar_len_o, t_m.len);
        end
        if (mst_ar_ready_i) begin
          if (exp_ar_q.size() > 0) void'(exp_ar_q.pop_front());
          m_phase = 2;
        end
      end else begin
        check("ar_ready_busy", slv_ar_ready_o, 0);
        exp_v = '0;
        if (mst_r_valid_i) exp_v[m_port] = 1'b1;
        check("r_valid_route", slv_r_valid_o, exp_v);
        check("r_ready_mirror", mst_r_ready_o, slv_r_ready_i[m_port]);
        if (mst_r_valid_i && slv_r_ready_i[m_port]) begin
          if (exp_r_q.size() == 0) begin
            check("r_beat_expected", 1, 0);
          end else begin
            b_m = exp_r_q.pop_front();
            check("r_id", slv_r_id_o, m_id);
            check("r_data", slv_r_data_o, b_m.data);
            check("r_resp", slv_r_resp_o, b_m.resp);
            check("r_last", slv_r_last_o, b_m.last);
            err_due = b_m.err;
          end
          if (mst_r_last_i) m_phase = 0;
        end
      end
    end
  end

  logic [NP-1:0]  v_valid;
  logic [IW-1:0]  v_id   [NP];
  logic [AW-1:0]  v_addr [NP];
  logic [7:0]     v_len  [NP];
  int             left   [NP];
  logic [NP-1:0]  ar_hs;
  logic           mar_hs, mr_hs, r_vld, done;
  logic [MIW-1:0] cur_rid;
  ar_t            t_d;
  beat_t          b_d;
  int             nb, cyc;

  task automatic drive_ar();
    for (int p = 0; p < NP; p++) begin
      slv_ar_id_i[p*IW +: IW]   = v_id[p];
      slv_ar_addr_i[p*AW +: AW] = v_addr[p];
      slv_ar_len_i[p*8 +: 8]    = v_len[p];
    end
    slv_ar_valid_i = v_valid;
  endtask

  initial begin
    rst_i = 1'b1;
    slv_ar_valid_i = '0; slv_ar_id_i = '0; slv_ar_addr_i = '0; slv_ar_len_i = '0;
    slv_r_ready_i = '0; mst_ar_ready_i = 1'b0;
    mst_r_valid_i = 1'b0; mst_r_id_i = '0; mst_r_data_i = '0; mst_r_resp_i = '0; mst_r_last_i = 1'b0;
    v_valid = '0; r_vld = 1'b0; done = 1'b0; cur_rid = '0;
    for (int p = 0; p < NP; p++) begin
      v_id[p] = '0; v_addr[p] = '0; v_len[p] = '0; left[p] = REQS;
    end
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("reset_busy", busy_o, 0);
    check("reset_mst_ar_valid", mst_ar_valid_o, 0);
    check("reset_len_err", len_err_o, 0);
    check("reset_slv_ar_ready", slv_ar_ready_o, 0);

    cyc = 0;
    while (!done && cyc < 30000) begin
      @(negedge clk);
      ar_hs  = slv_ar_valid_i & slv_ar_ready_o;
      mar_hs = mst_ar_valid_o & mst_ar_ready_i;
      mr_hs  = mst_r_valid_i & mst_r_ready_o;
      @(posedge clk);
      #1;
      cyc++;
      for (int p = 0; p < NP; p++) begin
        if (ar_hs[p]) v_valid[p] = 1'b0;
        if (!v_valid[p] && left[p] > 0 && $urandom_range(2) == 0) begin
          v_valid[p] = 1'b1;
          v_id[p]    = IW'($urandom);
          v_addr[p]  = $urandom;
          v_len[p]   = 8'($urandom_range(7));
          left[p]--;
        end
      end
      drive_ar();
      if (mar_hs) begin
        if (txn_q.size() == 0) begin
          check("txn_available", 1, 0);
        end else begin
          t_d = txn_q.pop_front();
          cur_rid = {t_d.port[IXW-1:0], t_d.id};
          nb = int'(t_d.len) + 1;
          if ($urandom_range(4) == 0) nb = $urandom_range(int'(t_d.len) + 2, 1);
          for (int k = 0; k < nb; k++) begin
            b_d.data = {$urandom, $urandom};
            b_d.resp = 2'($urandom_range(3));
            b_d.last = (k == nb - 1);
            b_d.err  = (b_d.last && k != int'(t_d.len)) || (!b_d.last && k == int'(t_d.len));
            src_q.push_back(b_d);
            exp_r_q.push_back(b_d);
          end
        end
      end
      if (mr_hs) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        r_vld = 1'b0;
      end
      if (!r_vld && src_q.size() > 0 && $urandom_range(3) != 0) r_vld = 1'b1;
      mst_r_valid_i = r_vld;
      if (src_q.size() > 0) begin
        mst_r_id_i   = cur_rid;
        mst_r_data_i = src_q[0].data;
        mst_r_resp_i = src_q[0].resp;
        mst_r_last_i = src_q[0].last;
      end
      mst_ar_ready_i = ($urandom_range(3) == 0);
      slv_r_ready_i  = NP'($urandom);
      done = (v_valid == '0) && (src_q.size() == 0) && (txn_q.size() == 0) &&
             (exp_ar_q.size() == 0) && (exp_r_q.size() == 0) && !busy_o;
      for (int p = 0; p < NP; p++) if (left[p] > 0) done = 1'b0;
    end
    if (!done) check("random_phase_timeout", 0, 1);

    // Mid-burst reset: port 0 reads 4 beats, reset after 2, then rr_ptr must be back at 0.
    mst_r_valid_i = 1'b0; mst_r_last_i = 1'b0; slv_r_ready_i = '1; mst_ar_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    v_valid = 3'b001; v_id[0] = 4'd5; v_addr[0] = 32'h2000; v_len[0] = 8'd3;
    drive_ar();
    @(negedge clk);
    check("dir_grant_port0", slv_ar_ready_o, 3'b001);
    @(posedge clk);
    #1;
    v_valid = '0;
    drive_ar();
    for (int k = 0; k < 4; k++) begin
      b_d.data = 64'hA000 + 64'(k); b_d.resp = 2'b00; b_d.last = (k == 3); b_d.err = 1'b0;
      exp_r_q.push_back(b_d);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      mst_r_valid_i = 1'b1; mst_r_id_i = {2'b00, 4'd5};
      mst_r_data_i = 64'hA000 + 64'(k); mst_r_resp_i = 2'b00; mst_r_last_i = 1'b0;
    end
    @(posedge clk);
    #1;
    mst_r_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_mst_r_ready", mst_r_ready_o, 0);
    check("rst_mid_mst_ar_valid", mst_ar_valid_o, 0);
    check("rst_mid_slv_r_valid", slv_r_valid_o, 0);
    check("rst_mid_len_err", len_err_o, 0);
    @(posedge clk);
    #1;
    v_valid = 3'b101; v_id[2] = 4'd9; v_addr[2] = 32'h3000; v_len[2] = 8'd0;
    drive_ar();
    @(negedge clk);
    check("rst_rr_ptr_zero", slv_ar_ready_o, 3'b001);
    @(posedge clk);
    #1;
    v_valid = '0;
    drive_ar();
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
